calc_host_seq: RTL and testbench

- Host-side sequencer directly upstream of the calculator device FSM (dev_fsm).
- Accepts one complete calculator request per handshake (command plus up to two operands) and serialises it onto the device byte bus: cs and command, then op_1, then op_2.
- For read commands, waits for drdy and returns the captured result.
- Adds busy-wait and drdy timeouts so a hung device cannot stall the host.

---
 rtl/calc_host_seq_if.sv | 47 ++++
 rtl/calc_host_seq.sv | 183 ++++++++++++++++++
 tb/tb_calc_host_seq.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_host_seq_if.sv
// Command bit map and host/device bus bundle for calc_host_seq.
// One request in, one response out, byte-serial device port.
package cmd_bits;
    localparam int b_addop  = 0;
    localparam int b_subop  = 1;
    localparam int b_addres = 2;
    localparam int b_subres = 3;
    localparam int b_op_2   = 4;
    localparam int b_tx     = 5;
endpackage

interface calc_host_seq_if #(
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_cmd;
    logic [DW-1:0] req_op1;
    logic [DW-1:0] req_op2;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          dev_cs;
    logic [DW-1:0] dev_din;
    logic          dev_busy;
    logic [DW-1:0] dev_dout;
    logic          dev_drdy;

    modport slave (
        input  req_valid, req_cmd, req_op1, req_op2,
        input  rsp_ready,
        input  dev_busy, dev_dout, dev_drdy,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err,
        output dev_cs, dev_din
    );

    modport master (
        output req_valid, req_cmd, req_op1, req_op2,
        output rsp_ready,
        output dev_busy, dev_dout, dev_drdy,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err,
        input  dev_cs, dev_din
    );
endinterface

// File: rtl/calc_host_seq.sv
// Host-side sequencer: serialises a request onto the device bus,
// waits for busy/drdy with timeouts, and returns a response.
module calc_host_seq
    import cmd_bits::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    calc_host_seq_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WBUSY,
        S_CMD,
        S_OP1,
        S_OP2,
        S_WRDY,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cmd_q, cmd_d;
    logic [DW-1:0] op1_q, op1_d;
    logic [DW-1:0] op2_q, op2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;
    logic          cs_q, cs_d;
    logic [DW-1:0] din_q, din_d;
    logic          valid_q, valid_d;
    logic          rdy_q, rdy_d;

    logic          need_op1;
    logic          need_op2;
    logic          need_rd;
    logic [CW-1:0] cnt_inc;
    state_t        after_cmd;
    state_t        after_op1;
    state_t        after_op2;

    assign need_op1 = cmd_q[b_addop] | cmd_q[b_subop]
                    | cmd_q[b_addres] | cmd_q[b_subres];
    assign need_op2 = cmd_q[b_op_2];
    assign need_rd  = cmd_q[b_tx];

    // Saturating so a huge TIMEOUT never lets the count wrap.
    assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        after_op2 = need_rd ? S_WRDY : S_RESP;
        after_op1 = need_op2 ? S_OP2 : after_op2;
        after_cmd = need_op1 ? S_OP1 : after_op1;
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    cmd_d   = bus.req_cmd;
                    op1_d   = bus.req_op1;
                    op2_d   = bus.req_op2;
                    cnt_d   = '0;
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_WBUSY;
                end
            end
            S_WBUSY: begin
                if (!bus.dev_busy) begin
                    state_d = S_CMD;
                end else if (cnt_q == CLAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_CMD: begin
                cnt_d   = '0;
                state_d = after_cmd;
            end
            S_OP1: begin
                cnt_d   = '0;
                state_d = after_op1;
            end
            S_OP2: begin
                cnt_d   = '0;
                state_d = after_op2;
            end
            S_WRDY: begin
                // A late drdy coinciding with the timeout still wins.
                if (bus.dev_drdy) begin
                    data_d  = bus.dev_dout;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CLAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                data_d  = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cs_d    = (state_d == S_CMD);
        valid_d = (state_d == S_RESP);
        rdy_d   = (state_d == S_IDLE);
        din_d   = '0;
        unique case (1'b1)
            (state_d == S_CMD): din_d = cmd_d;
            (state_d == S_OP1): din_d = op1_d;
            (state_d == S_OP2): din_d = op2_d;
            default:            din_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            din_q   <= '0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            din_q   <= din_d;
            valid_q <= valid_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.dev_cs    = cs_q;
    assign bus.dev_din   = din_q;

endmodule

// File: tb/tb_calc_host_seq.sv
// Randomised scoreboard bench for calc_host_seq with a
// behavioural device model and cycle-accurate expectations.
module tb_calc_host_seq;
    import cmd_bits::*;

    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    calc_host_seq_if #(.DW(DW)) bus ();

    calc_host_seq #(.DW(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0][DW-1:0] b;
        int n;
        int cyc;
    } bus_t;

    typedef struct {
        logic [DW-1:0] data;
        logic err;
        int cyc;
    } rsp_t;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    bus_t bq[$];
    rsp_t rq[$];
    bus_t cur;
    int ph = 0;
    rsp_t er;
    logic have = 1'b0;
    int rd_d = 0;
    logic [DW-1:0] rd_v = '0;
    int dcnt = 0;
    int rdy_lo = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at cyc %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errs++;
        $display("FAIL %s at cyc %0d", nm, cyc);
    endtask

    // Device: drdy pulse rd_d cycles after the cs cycle.
    always @(negedge clk) begin
        bus.dev_drdy = 1'b0;
        bus.dev_dout = DW'($urandom);
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                bus.dev_drdy = 1'b1;
                bus.dev_dout = rd_v;
            end
        end
        if (rst && bus.dev_cs && rd_d > 0) dcnt = rd_d;
    end

    always @(posedge clk) begin
        #1;
        if (rdy_lo > 0) begin
            bus.rsp_ready = 1'b0;
            if (bus.rsp_valid) rdy_lo--;
        end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Device-bus monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (ph > 0 && ph <= cur.n) begin
                chk("op_cs", 32'(bus.dev_cs), 32'd0);
                chk("op_din", 32'(bus.dev_din), 32'(cur.b[ph]));
                ph++;
            end else begin
                ph = 0;
                if (bus.dev_cs) begin
                    if (bq.size() == 0) begin
                        fail_now("cs_unexpected");
                    end else begin
                        cur = bq.pop_front();
                        chk("cs_cyc", cyc, cur.cyc);
                        chk("cmd_din", 32'(bus.dev_din), 32'(cur.b[0]));
                        ph = 1;
                    end
                end else begin
                    chk("idle_din", 32'(bus.dev_din), 32'd0);
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst && bus.rsp_valid) begin
            if (!have) begin
                if (rq.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    er = rq.pop_front();
                    have = 1'b1;
                    chk("rsp_cyc", cyc, er.cyc);
                end
            end
            if (have) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(er.data));
                chk("rsp_err", 32'(bus.rsp_err), 32'(er.err));
                chk("rsp_reqrdy", 32'(bus.req_ready), 32'd0);
                if (bus.rsp_ready) have = 1'b0;
            end
        end
    end

    task automatic issue(input logic [DW-1:0] c,
                         input logic [DW-1:0] o1,
                         input logic [DW-1:0] o2,
                         input int b, input int d,
                         input logic [DW-1:0] v,
                         output int acc);
        bus_t e;
        rsp_t r;
        int k;
        int idx;
        int cs;
        k = 0;
        @(negedge clk);
        while (!bus.req_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        acc = cyc;
        if (!bus.req_ready) begin
            fail_now("req_ready_wait");
            return;
        end
        e.b = '0;
        e.b[0] = c;
        idx = 1;
        if (c[b_addop] || c[b_subop] || c[b_addres] || c[b_subres]) begin
            e.b[idx] = o1;
            idx++;
        end
        if (c[b_op_2]) begin
            e.b[idx] = o2;
            idx++;
        end
        e.n = idx - 1;
        e.cyc = acc + b + 2;
        cs = e.cyc;
        r.data = '0;
        r.err = 1'b0;
        if (b >= TO) begin
            r.err = 1'b1;
            r.cyc = acc + TO + 1;
        end else begin
            bq.push_back(e);
            if (!c[b_tx]) begin
                r.cyc = cs + e.n + 1;
            end else if (d >= e.n + 1 && d <= e.n + TO) begin
                r.data = v;
                r.cyc = cs + d + 1;
            end else begin
                r.err = 1'b1;
                r.cyc = cs + e.n + TO + 1;
            end
        end
        rq.push_back(r);
        rd_d = c[b_tx] ? d : 0;
        rd_v = v;
        bus.req_valid = 1'b1;
        bus.req_cmd = c;
        bus.req_op1 = o1;
        bus.req_op2 = o2;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_cmd = DW'($urandom);
        bus.req_op1 = DW'($urandom);
        bus.req_op2 = DW'($urandom);
        bus.dev_busy = (b > 0);
        if (b > 0) begin
            repeat (b) @(posedge clk);
            #1;
            bus.dev_busy = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int k;
        logic [DW-1:0] add2;
        logic [DW-1:0] rdc;
        add2 = DW'((1 << b_op_2) | (1 << b_addop));
        rdc = DW'(1 << b_tx);
        bus.req_valid = 1'b0;
        bus.req_cmd = '0;
        bus.req_op1 = '0;
        bus.req_op2 = '0;
        bus.dev_busy = 1'b0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus.req_valid = 1'($urandom);
            bus.req_cmd = DW'($urandom);
            bus.dev_busy = 1'($urandom);
            #1;
            chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
            chk("rst_cs", 32'(bus.dev_cs), 32'd0);
            chk("rst_din", 32'(bus.dev_din), 32'd0);
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
            chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.dev_busy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_cs", 32'(bus.dev_cs), 32'd0);

        issue(add2, 8'h12, 8'h34, 0, 0, 8'h00, acc);
        issue(rdc, 8'h00, 8'h00, 0, 3, 8'h46, acc);
        issue(add2, 8'h01, 8'h02, 10, 0, 8'h00, acc);
        issue(rdc, 8'h00, 8'h00, 0, 0, 8'h00, acc);
        issue(rdc, 8'h00, 8'h00, 0, TO, 8'hc3, acc);
        issue(rdc, 8'h00, 8'h00, 0, TO + 1, 8'h3c, acc);
        issue(add2, 8'h05, 8'h06, 20, 0, 8'h00, acc);
        issue(add2, 8'h07, 8'h08, TO - 1, 0, 8'h00, acc);
        issue(add2, 8'h09, 8'h0a, TO, 0, 8'h00, acc);
        issue(8'h00, 8'h55, 8'haa, 0, 0, 8'h00, acc);
        rdy_lo = 5;
        issue(DW'((1 << b_tx) | (1 << b_subop)), 8'h11, 8'h22,
              1, 4, 8'h5a, acc);

        issue(add2, 8'h77, 8'h88, 0, 0, 8'h00, acc);
        k = 0;
        while (cyc != acc + 3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_cs", 32'(bus.dev_cs), 32'd0);
        chk("mid_rst_din", 32'(bus.dev_din), 32'd0);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        bq.delete();
        rq.delete();
        have = 1'b0;
        ph = 0;
        dcnt = 0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        issue(add2, 8'h9a, 8'hbc, 0, 0, 8'h00, acc);

        for (int i = 0; i < 60; i++) begin
            int r;
            int b;
            r = $urandom_range(0, 9);
            if (r < 6) b = $urandom_range(0, 3);
            else if (r < 8) b = $urandom_range(4, 14);
            else b = $urandom_range(15, 18);
            issue(DW'($urandom), DW'($urandom), DW'($urandom), b,
                  $urandom_range(0, 20), DW'($urandom), acc);
        end

        k = 0;
        while ((rq.size() != 0 || have || !bus.req_ready) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (rq.size() != 0 || bq.size() != 0 || have)
            fail_now("drain_timeout");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
